// File: rtl/rank_filter_3x3_if.sv
// Pixel stream bundle for the 3x3 rank-order filter.
// The master drives the input pixel stream and the per-pixel mode.
// The slave (the filter) returns the filtered pixel strobe.
interface rank_filter_3x3_if #(
   parameter int DW = 12
) ();
   logic [DW-1:0] datain;
   logic          datain_en;
   logic          sof;
   logic [1:0]    mode;
   logic [DW-1:0] dataout;
   logic          dataout_en;

   modport master (
      output datain,
      output datain_en,
      output sof,
      output mode,
      input  dataout,
      input  dataout_en
   );

   modport slave (
      input  datain,
      input  datain_en,
      input  sof,
      input  mode,
      output dataout,
      output dataout_en
   );
endinterface

// File: rtl/rank_filter_3x3.sv
// 3x3 rank-order filter (median / min / max) for a raster pixel stream.
// Two internal line buffers plus the incoming pixel form each new window
// column. Each valid window then runs through a 3-stage pipeline:
// pairwise compare, rank count, rank select. Ties are broken by window
// position, so the nine ranks always form a permutation of 0..8.
module rank_filter_3x3 #(
   parameter int DW    = 12,
   parameter int IMG_W = 640
) (
   input logic               clk,
   input logic               rst_n,
   rank_filter_3x3_if.slave  bus
);
   localparam int AW = $clog2(IMG_W);

   // Rank of element k: strictly-smaller count plus equal-valued elements at
   // lower window positions. That tie-break keeps the ranks unique.
   function automatic logic [3:0] rank_of(input logic [8:0] lt_row,
                                          input logic [8:0] eq_row,
                                          input int         k);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int j = 0; j < 9; j++) begin
         if (lt_row[j] || (eq_row[j] && (j < k))) begin
            cnt = cnt + 4'd1;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

   // ---------------- position counters and window ----------------
   logic [AW-1:0] col_q, col_d, cur_col_s;
   logic [1:0]    row_q, row_d, cur_row_s;
   logic          win_valid_s;
   logic [DW-1:0] lb0_q [IMG_W];
   logic [DW-1:0] lb1_q [IMG_W];
   logic [DW-1:0] lb0_rd_s, lb1_rd_s;
   logic [DW-1:0] win_q [3][3];        // [column 0=oldest..2=newest][row 0=top..2=bottom]
   logic          v0_q;
   logic [1:0]    mode0_q;
   logic [DW-1:0] x_s [9];

   // ---------------- pipeline stages ----------------
   logic [DW-1:0] x1_q [9];
   logic [8:0]    lt1_q [9];
   logic [8:0]    eq1_q [9];
   logic          v1_q;
   logic [1:0]    mode1_q;
   logic [DW-1:0] x2_q [9];
   logic [3:0]    rank2_q [9];
   logic          v2_q;
   logic [1:0]    mode2_q;
   logic [3:0]    target_s;
   logic [DW-1:0] sel_s;
   logic [DW-1:0] dataout_q;
   logic          dataout_en_q;

   // Current pixel position (sof forces (0,0)), next counter state and window validity
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_valid_s = 1'b0;
      if (bus.sof) begin
         cur_col_s = {AW{1'b0}};
         cur_row_s = 2'd0;
      end else begin
         cur_col_s = col_q;
         cur_row_s = row_q;
      end
      if (bus.datain_en) begin
         win_valid_s = (cur_row_s == 2'd2) && (cur_col_s >= AW'(2));
         if (cur_col_s == AW'(IMG_W - 1)) begin
            col_d = {AW{1'b0}};
            if (cur_row_s == 2'd2) begin
               row_d = 2'd2;
            end else begin
               row_d = cur_row_s + 2'd1;
            end
         end else begin
            col_d = cur_col_s + AW'(1);
            row_d = cur_row_s;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   assign lb0_rd_s = lb0_q[cur_col_s];
   assign lb1_rd_s = lb1_q[cur_col_s];

   // Line buffers: the previous line moves down into lb1 as the new pixel enters lb0
   always_ff @(posedge clk) begin
      if (bus.datain_en) begin
         lb0_q[cur_col_s] <= bus.datain;
         lb1_q[cur_col_s] <= lb0_rd_s;
      end else begin
         lb0_q[cur_col_s] <= lb0_q[cur_col_s];
         lb1_q[cur_col_s] <= lb1_q[cur_col_s];
      end
   end

   // Counters, window shift and stage-0 valid/mode capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= {AW{1'b0}};
         row_q   <= 2'd0;
         v0_q    <= 1'b0;
         mode0_q <= 2'd0;
         for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
               win_q[c][r] <= {DW{1'b0}};
            end
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         v0_q    <= win_valid_s;
         mode0_q <= bus.mode;
         if (bus.datain_en) begin
            win_q[0]    <= win_q[1];
            win_q[1]    <= win_q[2];
            win_q[2][0] <= lb1_rd_s;
            win_q[2][1] <= lb0_rd_s;
            win_q[2][2] <= bus.datain;
         end else begin
            win_q <= win_q;
         end
      end
   end

   // Flatten the window into nine candidates, k = 3*column + row
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < 3; r++) begin
            x_s[c*3 + r] = win_q[c][r];
         end
      end
   end

   // Stage 1: copy the window into the pipe and register all pairwise compares
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         mode1_q <= 2'd0;
         for (int k = 0; k < 9; k++) begin
            x1_q[k]  <= {DW{1'b0}};
            lt1_q[k] <= 9'd0;
            eq1_q[k] <= 9'd0;
         end
      end else begin
         v1_q    <= v0_q;
         mode1_q <= mode0_q;
         for (int k = 0; k < 9; k++) begin
            x1_q[k] <= x_s[k];
            for (int j = 0; j < 9; j++) begin
               lt1_q[k][j] <= (x_s[j] < x_s[k]);
               eq1_q[k][j] <= (j != k) && (x_s[j] == x_s[k]);
            end
         end
      end
   end

   // Stage 2: turn compare vectors into ranks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         mode2_q <= 2'd0;
         for (int k = 0; k < 9; k++) begin
            x2_q[k]    <= {DW{1'b0}};
            rank2_q[k] <= 4'd0;
         end
      end else begin
         v2_q    <= v1_q;
         mode2_q <= mode1_q;
         for (int k = 0; k < 9; k++) begin
            x2_q[k]    <= x1_q[k];
            rank2_q[k] <= rank_of(lt1_q[k], eq1_q[k], k);
         end
      end
   end

   // Rank wanted by the mode (reserved mode behaves as median) and the matching pixel
   always_comb begin
      case (mode2_q)
         2'd1:    target_s = 4'd0;
         2'd2:    target_s = 4'd8;
         default: target_s = 4'd4;
      endcase
      sel_s = {DW{1'b0}};
      for (int k = 0; k < 9; k++) begin
         if (rank2_q[k] == target_s) begin
            sel_s = x2_q[k];
         end else begin
            sel_s = sel_s;
         end
      end
   end

   // Stage 3: registered output; dataout holds across bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataout_q    <= {DW{1'b0}};
         dataout_en_q <= 1'b0;
      end else begin
         dataout_en_q <= v2_q;
         if (v2_q) begin
            dataout_q <= sel_s;
         end else begin
            dataout_q <= dataout_q;
         end
      end
   end

   assign bus.dataout    = dataout_q;
   assign bus.dataout_en = dataout_en_q;
endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3 with a 4-pixel-wide image.
// A frame-level model sorts each 3x3 neighbourhood of the sent image and
// schedules the expected pixel three clocks after its last input; a single
// negedge process checks dataout/dataout_en against it on every cycle.
// Literal expectations per test pin the model itself.
module tb_rank_filter_3x3;
   localparam int DW    = 12;
   localparam int IMG_W = 4;

   typedef struct {
      int            cyc;
      logic [DW-1:0] val;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;

   exp_t          expq[$];
   logic [DW-1:0] cap[$];
   logic [DW-1:0] last_val;
   logic [DW-1:0] img [4][4];

   rank_filter_3x3_if #(.DW(DW)) bus ();

   rank_filter_3x3 #(.DW(DW), .IMG_W(IMG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every-cycle comparison against the model schedule
   always @(negedge clk) begin
      logic          exp_en;
      logic [DW-1:0] exp_dat;
      exp_en  = (expq.size() > 0) && (expq[0].cyc == cyc);
      exp_dat = exp_en ? expq[0].val : last_val;
      check("dataout_en", {31'd0, bus.dataout_en}, {31'd0, exp_en});
      check("dataout", {20'd0, bus.dataout}, {20'd0, exp_dat});
      if (exp_en) begin
         last_val = expq[0].val;
         void'(expq.pop_front());
      end
      if (bus.dataout_en === 1'b1) cap.push_back(bus.dataout);
   end

   function automatic logic [DW-1:0] pix(input int pat, input int r, input int c);
      case (pat)
         0:       return DW'(16 * r + c);
         1:       return 12'h5A5;
         default: return (r == 1 && c == 1) ? 12'hFFF : 12'h000;
      endcase
   endfunction

   // Sort the neighbourhood ending at (r,c) and pick the rank the mode asks for
   function automatic logic [DW-1:0] model(input int r, input int c, input logic [1:0] md);
      logic [DW-1:0] v [9];
      logic [DW-1:0] t;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v[i*3 + j] = img[r-2+i][c-2+j];
      for (int a = 0; a < 9; a++)
         for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
      case (md)
         2'd1:    return v[0];
         2'd2:    return v[8];
         default: return v[4];
      endcase
   endfunction

   // md 0..3 fixed mode; md 4 means mode = column index of each pixel
   task automatic send_frame(input int pat, input int md, input bit gaps, input int npix);
      for (int n = 0; n < npix; n++) begin
         int r, c;
         logic [1:0] m;
         r = n / 4;
         c = n % 4;
         m = (md == 4) ? 2'(c) : 2'(md);
         img[r][c]     = pix(pat, r, c);
         bus.datain    = img[r][c];
         bus.datain_en = 1'b1;
         bus.sof       = (n == 0);
         bus.mode      = m;
         @(posedge clk);
         #1;
         if (r >= 2 && c >= 2) expq.push_back('{cyc + 3, model(r, c, m)});
         bus.datain_en = 1'b0;
         bus.sof       = 1'b0;
         bus.mode      = 2'(~m);
         if (gaps) begin
            bus.datain = 12'h7E3;
            bus.sof    = 1'b1;
            @(posedge clk);
            #1;
            bus.sof    = 1'b0;
         end
      end
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic expect4(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
      logic [DW-1:0] e [4];
      e = '{a, b, c, d};
      check({name, "_count"}, cap.size(), 4);
      for (int i = 0; i < 4 && i < cap.size(); i++) check(name, {20'd0, cap[i]}, {20'd0, e[i]});
      cap.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; pass_cnt = 0; total_cnt = 0; last_val = '0;
      rst_n = 1'b0;
      bus.datain = '0; bus.datain_en = 1'b0; bus.sof = 1'b0; bus.mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dataout", {20'd0, bus.dataout}, 0);
      check("reset_en", {31'd0, bus.dataout_en}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1/2: ramp frame in every mode
      send_frame(0, 0, 1'b0, 16); drain(); expect4("t1_median", 17, 18, 33, 34);
      send_frame(0, 1, 1'b0, 16); drain(); expect4("t2_min", 0, 1, 16, 17);
      send_frame(0, 2, 1'b0, 16); drain(); expect4("t2_max", 34, 35, 50, 51);
      send_frame(0, 3, 1'b0, 16); drain(); expect4("t2_mode3", 17, 18, 33, 34);
      // Mode switched per pixel: col 2 max, col 3 reserved/median
      send_frame(0, 4, 1'b0, 16); drain(); expect4("t2_permode", 34, 18, 50, 34);

      // Test 3: all ties
      send_frame(1, 0, 1'b0, 16); drain(); expect4("t3_ties", 12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);

      // Test 4: single bright pixel
      send_frame(2, 0, 1'b0, 16); drain(); expect4("t4_median", 0, 0, 0, 0);
      send_frame(2, 2, 1'b0, 16); drain(); expect4("t4_max", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);

      // Test 5: bubbles every other clock
      send_frame(0, 0, 1'b1, 16); drain(); expect4("t5_gaps", 17, 18, 33, 34);

      // Test 6: reset right after pixel (2,2) is accepted
      send_frame(0, 0, 1'b0, 11);
      rst_n = 1'b0;
      #1;
      check("t6_rst_dataout", {20'd0, bus.dataout}, 0);
      check("t6_rst_en", {31'd0, bus.dataout_en}, 0);
      expq.delete();
      last_val = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cap.delete();
      drain();
      check("t6_no_strobe", cap.size(), 0);
      send_frame(0, 0, 1'b0, 16); drain(); expect4("t6_restart", 17, 18, 33, 34);

      check("model_queue_empty", expq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
